// File: rtl/mux_seq_ctrl.sv
// mux_seq_ctrl
//   Serial select/shift/negate scheduler. It evaluates N_OPS operations on one
//   shared datapath, one operation per clock. A per-operation config table
//   (key, shift, invert) is written through the cfg port while idle. Each run
//   is a start/done handshake, and the results land in a registered vector.
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   start               run request, accepted only in IDLE
//   in0_vec, in1_vec    packed signed operands, op i at [i*BW_IN +: BW_IN]
//   cfg_we/addr/key/shift/inv   config table write port (IDLE only)
//   busy                high while a run is in progress (state != IDLE)
//   done                one-cycle pulse when out_vec is complete
//   cfg_err             one-cycle pulse when a config write was rejected
//   out_vec             registered results, op i at [i*BW_OUT +: BW_OUT]
module mux_seq_ctrl #(
  parameter int N_OPS     = 4,
  parameter int BW_IN     = 16,
  parameter int BW_OUT    = 16,
  parameter int MAX_SHIFT = 7,
  localparam int AW = (N_OPS > 1) ? $clog2(N_OPS) : 1,
  localparam int SW = (MAX_SHIFT > 0) ? $clog2(MAX_SHIFT + 1) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N_OPS*BW_IN-1:0]  in0_vec,
  input  logic [N_OPS*BW_IN-1:0]  in1_vec,
  input  logic                    cfg_we,
  input  logic [AW-1:0]           cfg_addr,
  input  logic                    cfg_key,
  input  logic [SW-1:0]           cfg_shift,
  input  logic                    cfg_inv,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic [N_OPS*BW_OUT-1:0] out_vec
);

  // Internal arithmetic width: room for the largest shift plus sign. Widened
  // to BW_OUT if the output slot happens to be larger.
  localparam int EW = BW_IN + MAX_SHIFT + 1;
  localparam int RW = (EW > BW_OUT) ? EW : BW_OUT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                    state_r;
  logic [AW-1:0]             idx_r;
  logic [N_OPS*BW_IN-1:0]    in0_r;
  logic [N_OPS*BW_IN-1:0]    in1_r;
  logic                      key_r   [N_OPS];
  logic                      inv_r   [N_OPS];
  logic [SW-1:0]             shift_r [N_OPS];
  logic                      busy_r;
  logic                      done_r;
  logic                      cfg_err_r;
  logic [N_OPS*BW_OUT-1:0]   out_r;

  logic [BW_IN-1:0]          op0_s;
  logic [BW_IN-1:0]          op1_s;
  logic                      key_s;
  logic                      inv_s;
  logic [SW-1:0]             sh_s;
  logic [RW-1:0]             ext0_s;
  logic [RW-1:0]             ext1_s;
  logic [RW-1:0]             shl_s;
  logic [RW-1:0]             neg_s;
  logic [RW-1:0]             res_s;
  logic                      addr_ok_s;
  logic [SW-1:0]             shift_clamp_s;

  // Pick the snapshot operands and table entry of the current op index.
  always_comb begin
    op0_s = '0;
    op1_s = '0;
    key_s = 1'b0;
    inv_s = 1'b0;
    sh_s  = '0;
    for (int i = 0; i < N_OPS; i++) begin
      if (idx_r == AW'(i)) begin
        op0_s = in0_r[i*BW_IN +: BW_IN];
        op1_s = in1_r[i*BW_IN +: BW_IN];
        key_s = key_r[i];
        inv_s = inv_r[i];
        sh_s  = shift_r[i];
      end else begin
        op0_s = op0_s;
      end
    end
  end

  // Shared datapath: sign-extend, shift, optional negate, then select.
  always_comb begin
    ext0_s = {{(RW-BW_IN){op0_s[BW_IN-1]}}, op0_s};
    ext1_s = {{(RW-BW_IN){op1_s[BW_IN-1]}}, op1_s};
    shl_s  = ext1_s << sh_s;
    if (inv_s) begin
      neg_s = -shl_s;
    end else begin
      neg_s = shl_s;
    end
    if (key_s) begin
      res_s = ext0_s;
    end else begin
      res_s = neg_s;
    end
  end

  // Config write qualification: address range check and shift saturation.
  always_comb begin
    addr_ok_s = (32'(cfg_addr) < 32'(N_OPS));
    if (32'(cfg_shift) > 32'(MAX_SHIFT)) begin
      shift_clamp_s = SW'(MAX_SHIFT);
    end else begin
      shift_clamp_s = cfg_shift;
    end
  end

  // Sequencer FSM, config table and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      idx_r     <= '0;
      in0_r     <= '0;
      in1_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
      out_r     <= '0;
      for (int i = 0; i < N_OPS; i++) begin
        key_r[i]   <= 1'b0;
        inv_r[i]   <= 1'b0;
        shift_r[i] <= '0;
      end
    end else begin
      // The table is only writable while idle, so it is frozen during a run.
      // A write on the start edge lands before the first op reads it.
      cfg_err_r <= 1'b0;
      if (cfg_we) begin
        if ((state_r == ST_IDLE) && addr_ok_s) begin
          key_r[cfg_addr]   <= cfg_key;
          inv_r[cfg_addr]   <= cfg_inv;
          shift_r[cfg_addr] <= shift_clamp_s;
        end else begin
          cfg_err_r <= 1'b1;
        end
      end else begin
        cfg_err_r <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            in0_r   <= in0_vec;
            in1_r   <= in1_vec;
            idx_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_RUN: begin
          out_r[idx_r*BW_OUT +: BW_OUT] <= res_s[BW_OUT-1:0];
          if (idx_r == AW'(N_OPS - 1)) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_r + AW'(1);
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign cfg_err = cfg_err_r;
  assign out_vec = out_r;

endmodule

// File: tb/tb_mux_seq_ctrl.sv
// Testbench for mux_seq_ctrl. Instance u_a uses N_OPS=4, BW_IN=8, BW_OUT=12,
// MAX_SHIFT=3; instance u_b (N_OPS=3, BW_OUT=8, MAX_SHIFT=5) covers the
// narrow-output wrap, shift saturation and out-of-range address cases.
module tb_mux_seq_ctrl;

  logic        clk;
  logic        rst_n;
  // instance A
  logic        start;
  logic [31:0] in0_vec, in1_vec;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic        cfg_key;
  logic [1:0]  cfg_shift;
  logic        cfg_inv;
  logic        busy, done, cfg_err;
  logic [47:0] out_vec;
  // instance B
  logic        b_start;
  logic [23:0] b_in0, b_in1;
  logic        b_cfg_we;
  logic [1:0]  b_cfg_addr;
  logic        b_cfg_key;
  logic [2:0]  b_cfg_shift;
  logic        b_cfg_inv;
  logic        b_busy, b_done, b_cfg_err;
  logic [23:0] b_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int last_done = 0;

  // reference model state for instance A
  logic signed [7:0] v0 [4];
  logic signed [7:0] v1 [4];
  int m_key [4];
  int m_sh  [4];
  int m_inv [4];

  mux_seq_ctrl #(.N_OPS(4), .BW_IN(8), .BW_OUT(12), .MAX_SHIFT(3)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in0_vec(in0_vec), .in1_vec(in1_vec),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_key(cfg_key),
    .cfg_shift(cfg_shift), .cfg_inv(cfg_inv),
    .busy(busy), .done(done), .cfg_err(cfg_err), .out_vec(out_vec)
  );

  mux_seq_ctrl #(.N_OPS(3), .BW_IN(8), .BW_OUT(8), .MAX_SHIFT(5)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start),
    .in0_vec(b_in0), .in1_vec(b_in1),
    .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_key(b_cfg_key),
    .cfg_shift(b_cfg_shift), .cfg_inv(b_cfg_inv),
    .busy(b_busy), .done(b_done), .cfg_err(b_cfg_err), .out_vec(b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: plain integer multiply/negate, then keep bw LSBs.
  function automatic int calc(input int a, input int b, input int key,
                              input int sh, input int inv, input int bw);
    int t;
    t = b * (1 << sh);
    if (inv != 0) t = -t;
    if (key != 0) t = a;
    return t & ((1 << bw) - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < 4; i++) begin
      v0[i] = 8'($urandom);
      v1[i] = 8'($urandom);
    end
  endtask

  task automatic wr_cfg(input int a, input int k, input int s, input int v);
    cfg_we    = 1'b1;
    cfg_addr  = 2'(a);
    cfg_key   = 1'(k);
    cfg_shift = 2'(s);
    cfg_inv   = 1'(v);
    tick();
    cfg_we = 1'b0;
    chk("cfg_err_valid_write", 64'(cfg_err), 64'd0);
    m_key[a] = k;
    m_sh[a]  = s;
    m_inv[a] = v;
  endtask

  // One run on instance A. With disturb set, inputs change mid-run, start and
  // a config write are pulsed in RUN, and start is pulsed in the done cycle.
  task automatic run_a(input bit disturb);
    int lat;
    for (int i = 0; i < 4; i++) begin
      in0_vec[i*8 +: 8] = v0[i];
      in1_vec[i*8 +: 8] = v1[i];
    end
    start = 1'b1;
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    lat = 1;
    chk("busy_in_run", 64'(busy), 64'd1);
    while (done !== 1'b1 && lat < 20) begin
      if (disturb && lat == 2) begin
        in0_vec   = $urandom;
        in1_vec   = $urandom;
        start     = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = 2'($urandom_range(0, 3));
        cfg_key   = 1'b1;
        cfg_shift = 2'($urandom);
        cfg_inv   = 1'b1;
      end else if (disturb && lat == 3) begin
        start  = 1'b0;
        cfg_we = 1'b0;
        chk("cfg_err_in_run", 64'(cfg_err), 64'd1);
      end else if (disturb && lat == 4) begin
        chk("cfg_err_one_cycle", 64'(cfg_err), 64'd0);
      end
      tick();
      lat++;
    end
    chk("start_to_done_latency", 64'(lat), 64'd5);
    last_done = cyc_cnt;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("slot%0d", i), 64'(out_vec[i*12 +: 12]),
          64'(calc(int'(v0[i]), int'(v1[i]), m_key[i], m_sh[i], m_inv[i], 12)));
    end
    if (disturb) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("done_single_pulse", 64'(done), 64'd0);
      chk("busy_after_done", 64'(busy), 64'd0);
      tick();
      chk("start_in_done_ignored", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int d1;
    int lat;
    rst_n = 1'b0;
    start = 1'b0; in0_vec = '0; in1_vec = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_key = 1'b0; cfg_shift = '0; cfg_inv = 1'b0;
    b_start = 1'b0; b_in0 = '0; b_in1 = '0;
    b_cfg_we = 1'b0; b_cfg_addr = '0; b_cfg_key = 1'b0; b_cfg_shift = '0; b_cfg_inv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_key[i] = 0; m_sh[i] = 0; m_inv[i] = 0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_out_vec", 64'(out_vec), 64'd0);

    // default table passes in1 through
    randomize_ops();
    v1[0] = 8'sd1; v1[1] = 8'sd2; v1[2] = 8'sd3; v1[3] = 8'sd4;
    run_a(1'b0);
    chk("default_passthrough", 64'(out_vec), 64'h004_003_002_001);
    tick();

    // directed table
    wr_cfg(0, 1, 0, 0);
    wr_cfg(1, 0, 2, 0);
    wr_cfg(2, 0, 1, 1);
    wr_cfg(3, 0, 0, 0);
    randomize_ops();
    v0[0] = 8'sd127; v1[1] = -8'sd3; v1[2] = 8'sd5; v1[3] = -8'sd128;
    run_a(1'b1);
    chk("directed_table", 64'(out_vec), 64'hF80_FF6_FF4_07F);

    // config write on the same edge as start is used by that run
    randomize_ops();
    cfg_we = 1'b1; cfg_addr = 2'd3; cfg_key = 1'b0; cfg_shift = 2'd3; cfg_inv = 1'b1;
    m_key[3] = 0; m_sh[3] = 3; m_inv[3] = 1;
    run_a(1'b0);
    tick();

    // random tables and operands
    repeat (4) begin
      for (int i = 0; i < 4; i++) begin
        wr_cfg(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 1)));
      end
      randomize_ops();
      run_a(1'b1);
    end

    // back-to-back runs, second one with mid-run input changes
    randomize_ops();
    run_a(1'b0);
    d1 = last_done;
    tick();
    randomize_ops();
    run_a(1'b1);
    chk("back_to_back_period", 64'(last_done - d1), 64'd6);

    // abort mid-run after two ops
    randomize_ops();
    for (int i = 0; i < 4; i++) begin
      in0_vec[i*8 +: 8] = v0[i];
      in1_vec[i*8 +: 8] = v1[i];
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_out_vec", 64'(out_vec), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("abort_no_done", 64'(done), 64'd0);
    for (int i = 0; i < 4; i++) begin
      m_key[i] = 0; m_sh[i] = 0; m_inv[i] = 0;
    end
    randomize_ops();
    run_a(1'b0);
    tick();

    // instance B: narrow output wrap, shift saturation, bad address
    b_cfg_we = 1'b1; b_cfg_addr = 2'd0; b_cfg_key = 1'b0; b_cfg_shift = 3'd1; b_cfg_inv = 1'b0;
    tick();
    b_cfg_addr = 2'd1; b_cfg_shift = 3'd7; b_cfg_inv = 1'b1;
    tick();
    b_cfg_addr = 2'd2; b_cfg_shift = 3'd3; b_cfg_inv = 1'b1;
    tick();
    chk("b_cfg_err_valid", 64'(b_cfg_err), 64'd0);
    b_cfg_addr = 2'd3; b_cfg_key = 1'b1; b_cfg_shift = 3'd0; b_cfg_inv = 1'b0;
    tick();
    b_cfg_we = 1'b0;
    chk("b_cfg_err_bad_addr", 64'(b_cfg_err), 64'd1);
    tick();
    chk("b_cfg_err_cleared", 64'(b_cfg_err), 64'd0);
    b_in0 = 24'($urandom);
    b_in1 = {8'h80, 8'h01, 8'h7F};
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    lat = 1;
    while (b_done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("b_latency", 64'(lat), 64'd4);
    chk("b_slot0_wrap", 64'(b_out[7:0]), 64'(calc(0, 127, 0, 1, 0, 8)));
    chk("b_slot1_clamp", 64'(b_out[15:8]), 64'(calc(0, 1, 0, 5, 1, 8)));
    chk("b_slot2_negwrap", 64'(b_out[23:16]), 64'(calc(0, -128, 0, 3, 1, 8)));
    chk("b_out_const", 64'(b_out), 64'h00_E0_FE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
